// File: rtl/hpi_pkg.sv
// Shared types for the CY7C67200 host-port interface master: register selects,
// command kinds and the access sequencer states.
package hpi_pkg;

    typedef enum logic [1:0] {
        HPI_DATA    = 2'd0,
        HPI_MAILBOX = 2'd1,
        HPI_ADDRESS = 2'd2,
        HPI_STATUS  = 2'd3
    } hpi_reg_t;

    typedef enum logic [1:0] {
        KIND_RAM_RD  = 2'd0,
        KIND_RAM_WR  = 2'd1,
        KIND_MBX_WR  = 2'd2,
        KIND_STAT_RD = 2'd3
    } hpi_kind_t;

    typedef enum logic [3:0] {
        RST_HOLD,
        IDLE,
        WAIT_WR,
        SETUP,
        STROBE,
        HOLD,
        WAIT_RD,
        RECOV,
        DONE
    } hpi_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hpi_access_timer.sv
// Phase down-counter: loaded with a cycle count on phase entry, reports
// expiry in the last cycle of the phase (count == 1).
module hpi_access_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (load) begin
            count <= load_val;
        end else if (count > CNT_W'(1)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == CNT_W'(1));

endmodule

// File: rtl/hpi_burst_master.sv
// HPI bus master: turns burst/single-register commands into timed cs_n/r_n/w_n
// cycles, relying on the chip's address auto-increment for RAM bursts.
module hpi_burst_master
    import hpi_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 8,
    parameter int STROBE_CYC = 4,
    parameter int RECOV_CYC  = 2,
    parameter int RST_CYC    = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_kind,
    input  logic [15:0]       cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        otg_hpi_address,
    output logic              otg_hpi_cs_n,
    output logic              otg_hpi_r_n,
    output logic              otg_hpi_w_n,
    output logic [DATA_W-1:0] otg_hpi_data_out,
    output logic              otg_hpi_data_oe,
    input  logic [DATA_W-1:0] otg_hpi_data_in,
    output logic              otg_hpi_reset_n
);

    localparam int TMR_MAX = max3(STROBE_CYC, RECOV_CYC, RST_CYC);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    hpi_state_t        state, next_state;
    hpi_kind_t         kind_q;
    hpi_reg_t          reg_q;
    logic [LEN_W-1:0]  wcnt;
    logic [DATA_W-1:0] data_out_q;
    logic [DATA_W-1:0] rd_data_q;

    logic              acc_write;
    logic              more_data;
    logic              wr_take;
    logic              in_access;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_expired;

    hpi_access_timer #(.CNT_W(TMR_W)) u_timer (
        .clk      (clk_clk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Direction of the access currently in flight
    always_comb begin
        acc_write = 1'b0;
        case (reg_q)
            HPI_DATA:    acc_write = (kind_q == KIND_RAM_WR);
            HPI_MAILBOX: acc_write = 1'b1;
            HPI_ADDRESS: acc_write = 1'b1;
            default:     acc_write = 1'b0;
        endcase
    end

    // The ADDRESS phase is always followed by at least one DATA access.
    assign more_data = (reg_q == HPI_ADDRESS) || ((reg_q == HPI_DATA) && (wcnt != '0));

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= RST_HOLD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        wr_take    = 1'b0;
        unique case (state)
            RST_HOLD: if (tmr_expired) next_state = IDLE;
            IDLE: begin
                if (cmd_valid) begin
                    if (hpi_kind_t'(cmd_kind) == KIND_MBX_WR) begin
                        if (wr_valid) begin
                            next_state = SETUP;
                            wr_take    = 1'b1;
                        end else begin
                            next_state = WAIT_WR;
                        end
                    end else begin
                        next_state = SETUP;
                    end
                end
            end
            WAIT_WR: begin
                if (wr_valid) begin
                    next_state = SETUP;
                    wr_take    = 1'b1;
                end
            end
            SETUP:   next_state = STROBE;
            STROBE:  if (tmr_expired) next_state = HOLD;
            HOLD:    next_state = (acc_write || rd_ready) ? RECOV : WAIT_RD;
            WAIT_RD: if (rd_ready) next_state = RECOV;
            RECOV: begin
                if (tmr_expired) begin
                    if (!more_data) begin
                        next_state = DONE;
                    end else if (kind_q != KIND_RAM_WR) begin
                        next_state = SETUP;
                    end else if (wr_valid) begin
                        next_state = SETUP;
                        wr_take    = 1'b1;
                    end else begin
                        next_state = WAIT_WR;
                    end
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (reset_reset) begin
            wr_take = 1'b0;
        end
    end

    // Timer is reloaded on entry to each multi-cycle phase and throughout reset.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (reset_reset) begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(RST_CYC);
        end else if ((next_state == STROBE) && (state != STROBE)) begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(STROBE_CYC);
        end else if ((next_state == RECOV) && (state != RECOV)) begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(RECOV_CYC);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            kind_q     <= KIND_RAM_RD;
            reg_q      <= HPI_DATA;
            data_out_q <= '0;
            rd_data_q  <= '0;
        end else begin
            if ((state == IDLE) && cmd_valid) begin
                kind_q <= hpi_kind_t'(cmd_kind);
                wcnt   <= cmd_len;
                case (hpi_kind_t'(cmd_kind))
                    KIND_MBX_WR:  reg_q <= HPI_MAILBOX;
                    KIND_STAT_RD: reg_q <= HPI_STATUS;
                    default: begin
                        reg_q      <= HPI_ADDRESS;
                        data_out_q <= DATA_W'(cmd_addr);
                    end
                endcase
            end
            if (wr_take) begin
                data_out_q <= wr_data;
            end
            if ((state == STROBE) && tmr_expired && !acc_write) begin
                rd_data_q <= otg_hpi_data_in;
            end
            // Advance to the next DATA access; the chip increments its own address.
            if ((state == RECOV) && tmr_expired && more_data) begin
                if (reg_q == HPI_DATA) begin
                    wcnt <= wcnt - 1'b1;
                end
                reg_q <= HPI_DATA;
            end
        end
    end

    always_comb begin
        in_access        = (state == SETUP) || (state == STROBE) || (state == HOLD);
        cmd_ready        = (state == IDLE) && !reset_reset;
        wr_ready         = wr_take;
        rd_valid         = ((state == HOLD) && !acc_write) || (state == WAIT_RD);
        rd_data          = rd_data_q;
        busy             = !((state == RST_HOLD) || (state == IDLE) || (state == DONE));
        done             = (state == DONE);
        otg_hpi_address  = reg_q;
        otg_hpi_cs_n     = !in_access;
        otg_hpi_r_n      = !((state == STROBE) && !acc_write);
        otg_hpi_w_n      = !((state == STROBE) && acc_write);
        otg_hpi_data_out = data_out_q;
        otg_hpi_data_oe  = in_access && acc_write;
        otg_hpi_reset_n  = (state != RST_HOLD);
    end

endmodule
